// File: rtl/rotl_unshifter_if.sv
// Valid/ready bus for the rotate-left unshifter: an input side carrying word and amount,
// and an output side carrying the rotated word.
interface rotl_unshifter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rotl_unshifter.sv
// Multi-cycle rotate-left engine: one log-step stage per cycle, stage 2**idx applied when
// amt[idx] is set, so a word rotated right by c comes back to its original value.
module rotl_unshifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rotl_unshifter_if.slave bus,
  output logic            busy_o
);

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic [SHW-1:0]   idx_q, idx_d;

  logic             rot_bit;
  logic [WIDTH-1:0] rot_val;
  logic [2*WIDTH-1:0] dbl;

  // Upper half of {data,data} shifted left by 2**idx is data rotated left by 2**idx.
  always_comb begin
    rot_bit = 1'b0;
    rot_val = data_q;
    dbl     = '0;
    for (int s = 0; s < SHW; s++) begin
      if (idx_q == SHW'(s)) begin
        rot_bit = amt_q[s];
        dbl     = {data_q, data_q} << (1 << s);
        rot_val = dbl[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          amt_d   = bus.in_amt;
          idx_d   = '0;
          state_d = StRot;
        end
      end
      StRot: begin
        if (rot_bit) data_d = rot_val;
        idx_d = idx_q + SHW'(1);
        if (idx_q == SHW'(SHW - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      amt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode from state only, so reset drops out_valid immediately.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.out_data  = data_q;
    busy_o        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_rotl_unshifter.sv
// Scoreboard bench for rotl_unshifter: expected words are queued at issue time and
// popped when out_valid is seen.
module tb_rotl_unshifter;

  logic clk;
  logic rst_n;
  logic busy;

  rotl_unshifter_if #(.WIDTH(8), .SHW(3)) u_if ();

  rotl_unshifter #(.WIDTH(8), .SHW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  logic [7:0] sb[$];

  function automatic logic [7:0] model_rotr(input logic [7:0] d, input int c);
    logic [15:0] w;
    w = {d, 8'h00} >> c;
    return w[15:8] | w[7:0];
  endfunction

  function automatic logic [7:0] sb_pop();
    if (sb.size() == 0) return 8'hxx;
    return sb.pop_front();
  endfunction

  task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic [7:0] exp);
    int n;
    n = 0;
    while (u_if.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    u_if.in_data  = d;
    u_if.in_amt   = a;
    u_if.in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; gives up at 20.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (u_if.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.in_amt = '0; u_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (u_if.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, u_if.in_ready);
      end
      vectors++;
      if (u_if.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, u_if.out_valid);
      end
      vectors++;
      if (u_if.out_data !== 8'h00) begin
        miscompares++; $display("FAIL reset_out_data[%0d] got %h want 00", k, u_if.out_data);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [7:0] din [3] = '{8'h01, 8'h80, 8'hB4};
    logic [2:0] amt [3] = '{3'd1, 3'd1, 3'd5};
    logic [7:0] want[3] = '{8'h02, 8'h01, 8'h96};
    int lat;
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      issue(din[i], amt[i], want[i]);
      vectors++;
      if (busy !== 1'b1 || u_if.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_busy[%0d] busy=%b in_ready=%b want 1/0", i, busy, u_if.in_ready);
      end
      wait_valid(lat);
      vectors++;
      if (lat != 3) begin
        miscompares++; $display("FAIL basic_latency[%0d] got %0d want 3", i, lat);
      end
      exp = sb_pop();
      vectors++;
      if (u_if.out_data !== exp) begin
        miscompares++; $display("FAIL basic_data[%0d] got %h want %h", i, u_if.out_data, exp);
      end
      handshake();
    end
  endtask

  task automatic test_multistage();
    logic [7:0] din [2] = '{8'hA5, 8'h3C};
    logic [2:0] amt [2] = '{3'd0, 3'd7};
    logic [7:0] want[2] = '{8'hA5, 8'h1E};
    int lat;
    logic [7:0] exp;
    for (int i = 0; i < 2; i++) begin
      issue(din[i], amt[i], want[i]);
      wait_valid(lat);
      vectors++;
      if (lat != 3) begin
        miscompares++; $display("FAIL multi_latency[%0d] got %0d want 3", i, lat);
      end
      exp = sb_pop();
      vectors++;
      if (u_if.out_data !== exp) begin
        miscompares++; $display("FAIL multi_data[%0d] got %h want %h", i, u_if.out_data, exp);
      end
      handshake();
    end
  endtask

  task automatic test_roundtrip();
    int lat;
    int shown;
    logic [7:0] exp;
    shown = 0;
    for (int d = 0; d < 256; d++) begin
      for (int c = 0; c < 8; c++) begin
        issue(model_rotr(8'(d), c), 3'(c), 8'(d));
        wait_valid(lat);
        exp = sb_pop();
        vectors++;
        if (u_if.out_data !== exp || lat != 3) begin
          miscompares++;
          if (shown < 10) begin
            shown++;
            $display("FAIL roundtrip d=%h c=%0d got %h lat %0d want %h lat 3",
                     d[7:0], c, u_if.out_data, lat, exp);
          end
        end
        handshake();
      end
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    logic [7:0] exp;
    logic [7:0] held;
    int bad;
    issue(8'h5A, 3'd3, 8'hD2);
    wait_valid(lat);
    exp = sb_pop();
    vectors++;
    if (u_if.out_data !== exp) begin
      miscompares++; $display("FAIL bp_data got %h want %h", u_if.out_data, exp);
    end
    held = exp;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      u_if.in_valid = (k == 3);
      u_if.in_data  = 8'hFF;
      u_if.in_amt   = 3'd4;
      @(posedge clk); #1;
      if (u_if.out_data !== held || u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0) bad++;
    end
    u_if.in_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    end
    handshake();
    vectors++;
    if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", u_if.out_valid, u_if.in_ready);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (u_if.out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL bp_ignored_pulse got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    logic [7:0] exp;
    issue(8'hF0, 3'd2, 8'hC3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++;
    if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_abort out_valid=%b in_ready=%b busy=%b want 0/1/0",
               u_if.out_valid, u_if.in_ready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (u_if.out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen);
    end
    issue(8'hF0, 3'd2, 8'hC3);
    wait_valid(lat);
    exp = sb_pop();
    vectors++;
    if (u_if.out_data !== exp || lat != 3) begin
      miscompares++;
      $display("FAIL midrst_recover got %h lat %0d want %h lat 3", u_if.out_data, lat, exp);
    end
    handshake();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_multistage();
    test_back_pressure();
    test_reset_mid_op();
    test_roundtrip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired before end of run");
    $fatal(1);
  end

endmodule
